ps2_scancode_ctrl: RTL

Sequencer between the PS/2 byte receiver and the game logic. It synchronises the receiver's byte-complete strobe into the system clock domain and decodes PS/2 Set-2 prefix sequences (E0 extended, F0 break) into single key events. Events are queued in a small show-ahead FIFO with a valid/ready handshake, so consumers never see raw prefix bytes or have to track protocol state themselves.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_event_fifo.sv | 59 +++++
 rtl/ps2_scancode_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and event layout for the PS/2 scancode path.
// Build option: PS2_EXTENDED_EN enables E0 (extended) prefix decoding.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] PS2_ERR_00     = 8'h00;
    localparam logic [7:0] PS2_ERR_FF     = 8'hFF;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_EXT     = ST_EXT,
        S_BRK     = ST_BRK,
        S_EXT_BRK = ST_EXT_BRK
    } ps2_state_e;

    localparam int EVT_W        = 10;
    localparam int EVT_CODE_LSB = 0;
    localparam int EVT_CODE_MSB = 7;
    localparam int EVT_REL_BIT  = 8;
    localparam int EVT_EXT_BIT  = 9;

    // Bytes the receiver reports on a framing/parity error.
    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == PS2_ERR_00) || (b == PS2_ERR_FF);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic show-ahead synchronous FIFO with separate occupancy counter.
// Head entry is read combinationally from storage; no write-to-read bypass.
module ps2_event_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_rd;
    logic          w_wr;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    // Storage, pointers and occupancy; clear overrides push and pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 Set-2 prefix decoder: byte strobe synchroniser, E0/F0 FSM, event FIFO.
// Build option: PS2_EXTENDED_EN enables EXT / EXT_BRK states and evt_extended.
module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [7:0]    ps2_byte,
    input  logic          ps2_byte_valid,
    input  logic          clear,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [7:0]    evt_code,
    output logic          evt_release,
    output logic          evt_extended,
    output logic          overflow,
    output logic [CW-1:0] evt_count
);

`ifdef PS2_EXTENDED_EN
    localparam int FW = EVT_W;
`else
    localparam int FW = EVT_W - 1;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_strobe;
    ps2_state_e             r_state;
    ps2_state_e             w_next;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [FW-1:0]          w_entry;
    logic [FW-1:0]          w_head;
    logic                   w_is_ext;
    logic                   w_is_brk;
    logic                   w_is_err;
    logic                   r_ovf;

    // Synchronise the receiver strobe and detect its rising edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ps2_byte_valid};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_strobe = r_sync[SYNC_STAGES-1] && !r_hist;

    assign w_is_ext = (ps2_byte == PS2_PREFIX_EXT);
    assign w_is_brk = (ps2_byte == PS2_PREFIX_BRK);
    assign w_is_err = is_err_byte(ps2_byte);

    // Event flags follow from the state the final byte arrives in.
`ifdef PS2_EXTENDED_EN
    assign w_entry = {(r_state == S_EXT) || (r_state == S_EXT_BRK),
                      (r_state == S_BRK) || (r_state == S_EXT_BRK),
                      ps2_byte};
`else
    assign w_entry = {(r_state == S_BRK), ps2_byte};
`endif

    // Prefix state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next state and push decision, evaluated only on a byte strobe.
    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        if (clear) begin
            w_next = S_IDLE;
        end else if (w_strobe) begin
            case (r_state)
                S_IDLE: begin
                    unique case (1'b1)
                        w_is_err: w_next = S_IDLE;
`ifdef PS2_EXTENDED_EN
                        w_is_ext: w_next = S_EXT;
`else
                        w_is_ext: w_next = S_IDLE;
`endif
                        w_is_brk: w_next = S_BRK;
                        default:  w_push = 1'b1;
                    endcase
                end
`ifdef PS2_EXTENDED_EN
                S_EXT: begin
                    unique case (1'b1)
                        w_is_err: w_next = S_IDLE;
                        w_is_ext: w_next = S_EXT;
                        w_is_brk: w_next = S_EXT_BRK;
                        default: begin
                            w_push = 1'b1;
                            w_next = S_IDLE;
                        end
                    endcase
                end
                S_EXT_BRK: begin
                    w_next = S_IDLE;
                    w_push = !(w_is_err || w_is_ext || w_is_brk);
                end
`endif
                S_BRK: begin
                    w_next = S_IDLE;
                    w_push = !(w_is_err || w_is_ext || w_is_brk);
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign w_pop = evt_valid && evt_ready && !clear;

    ps2_event_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_clear (clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_entry),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (evt_count)
    );

    // Sticky drop flag; a same-cycle pop makes room so nothing is lost.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                          r_ovf <= 1'b0;
        else if (clear)                       r_ovf <= 1'b0;
        else if (w_push && w_full && !w_pop)  r_ovf <= 1'b1;
    end

    assign overflow    = r_ovf;
    assign evt_valid   = !w_empty;
    assign evt_code    = w_head[EVT_CODE_MSB:EVT_CODE_LSB];
    assign evt_release = w_head[EVT_REL_BIT];
`ifdef PS2_EXTENDED_EN
    assign evt_extended = w_head[EVT_EXT_BIT];
`else
    assign evt_extended = 1'b0;
`endif

endmodule
